// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared constants, state type and window helper for the mux scan sequencer
package mux_scan_pkg;

   localparam int SEL_W = 5;
   localparam int N_CH  = 1 << SEL_W;
   localparam int CNT_W = SEL_W + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HOLD = 2'd2
   } scan_state_t;

   // Number of channels visited from first to last inclusive, wrapping past the top channel.
   function automatic logic [SEL_W:0] win_len(input logic [SEL_W-1:0] first,
                                              input logic [SEL_W-1:0] last);
      logic [SEL_W-1:0] diff;
      diff = last - first;
      return {1'b0, diff} + (SEL_W+1)'(1);
   endfunction

endpackage

// File: rtl/mux_scan_accum.sv
// rtl/mux_scan_accum.sv - result word register and ones counter fed one sampled bit per cycle
module mux_scan_accum
   import mux_scan_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [SEL_W-1:0] idx,
   input  logic             bit_in,
   output logic [N_CH-1:0]  data,
   output logic [CNT_W-1:0] ones
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data <= '0;
         ones <= '0;
      end else if (clr) begin
         data <= '0;
         ones <= '0;
      end else if (en) begin
         data[idx] <= bit_in;
         ones      <= ones + CNT_W'(bit_in);
      end
   end

endmodule

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - steps the mux select across a channel window and returns the sampled word
module mux_scan_ctrl
   import mux_scan_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [SEL_W-1:0] first_sel,
   input  logic [SEL_W-1:0] last_sel,
   input  logic             mux_out,
   output logic [SEL_W-1:0] sel,
   output logic             busy,
   output logic [N_CH-1:0]  result_data,
   output logic [CNT_W-1:0] result_ones,
   output logic             result_valid,
   input  logic             result_ready
);

   scan_state_t      state, state_d;
   logic [SEL_W-1:0] sel_d;
   logic [SEL_W-1:0] last_q, last_d;
   logic             acc_clr, acc_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         sel    <= '0;
         last_q <= '0;
      end else begin
         state  <= state_d;
         sel    <= sel_d;
         last_q <= last_d;
      end
   end

   // The first channel is held in sel itself, so only the end of the window needs latching.
   always_comb begin
      state_d = state;
      sel_d   = sel;
      last_d  = last_q;
      acc_clr = 1'b0;
      acc_en  = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               last_d  = last_sel;
               sel_d   = first_sel;
               acc_clr = 1'b1;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (abort) begin
               acc_clr = 1'b1;
               state_d = IDLE;
            end else begin
               acc_en = 1'b1;
               if (sel == last_q) begin
                  state_d = HOLD;
               end else begin
                  sel_d = sel + SEL_W'(1);
               end
            end
         end
         HOLD: begin
            // Abort outranks the handshake so a cancelled result is never seen as consumed.
            if (abort) begin
               acc_clr = 1'b1;
               state_d = IDLE;
            end else if (result_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy         = (state == SCAN);
   assign result_valid = (state == HOLD);

   mux_scan_accum u_accum (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (acc_clr),
      .en     (acc_en),
      .idx    (sel),
      .bit_in (mux_out),
      .data   (result_data),
      .ones   (result_ones)
   );

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - self-checking bench for mux_scan_ctrl with a behavioural 32-to-1 mux
module tb_mux_scan_ctrl;
   import mux_scan_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [SEL_W-1:0] first_sel = '0;
   logic [SEL_W-1:0] last_sel = '0;
   logic             mux_out;
   logic [SEL_W-1:0] sel;
   logic             busy;
   logic [N_CH-1:0]  result_data;
   logic [CNT_W-1:0] result_ones;
   logic             result_valid;
   logic             result_ready = 1'b0;

   logic [31:0] inp = 32'hABCD_EF12;
   assign mux_out = inp[sel];

   mux_scan_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .abort        (abort),
      .first_sel    (first_sel),
      .last_sel     (last_sel),
      .mux_out      (mux_out),
      .sel          (sel),
      .busy         (busy),
      .result_data  (result_data),
      .result_ones  (result_ones),
      .result_valid (result_valid),
      .result_ready (result_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [5:0]  ones;
   } exp_t;

   typedef struct {
      logic [4:0]  f;
      logic [4:0]  l;
      logic [31:0] d;
      logic [5:0]  o;
      int          lat;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[4];
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_scan(input logic [4:0] f, input logic [4:0] l,
                           input logic [31:0] ed, input logic [5:0] eo, input int lat);
      exp_t       e;
      int         cyc;
      int         seq_bad;
      logic [4:0] es;
      @(negedge clk);
      first_sel = f;
      last_sel  = l;
      start     = 1'b1;
      e.data = ed;
      e.ones = eo;
      sb_q.push_back(e);
      @(negedge clk);
      start   = 1'b0;
      cyc     = 0;
      seq_bad = 0;
      es      = f;
      while (!result_valid && cyc < 100) begin
         if (sel !== es || busy !== 1'b1) seq_bad++;
         es = es + 5'd1;
         @(negedge clk);
         cyc++;
      end
      chk("sel_sequence", 64'(seq_bad), 64'd0);
      chk("latency", 64'(cyc), 64'(lat));
      chk("win_len", 64'(win_len(f, l)), 64'(lat));
      chk("hold_sel", 64'(sel), 64'(l));
      chk("hold_busy", 64'(busy), 64'd0);
      if (sb_q.size() == 0) begin
         chk("scoreboard_empty", 64'd1, 64'd0);
      end else begin
         e = sb_q.pop_front();
         chk("result_data", 64'(result_data), 64'(e.data));
         chk("result_ones", 64'(result_ones), 64'(e.ones));
      end
   endtask

   task automatic handshake();
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      chk("hs_valid_low", 64'(result_valid), 64'd0);
      chk("hs_busy_low", 64'(busy), 64'd0);
   endtask

   task automatic wait_sel(input logic [4:0] target, input string name);
      int k;
      k = 0;
      while (sel !== target && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk(name, 64'(sel), 64'(target));
   endtask

   initial begin
      int vcnt;
      vecs[0] = '{f: 5'd0,  l: 5'd31, d: 32'hABCD_EF12, o: 6'd19, lat: 32};
      vecs[1] = '{f: 5'd4,  l: 5'd7,  d: 32'h0000_0010, o: 6'd1,  lat: 4};
      vecs[2] = '{f: 5'd30, l: 5'd1,  d: 32'h8000_0002, o: 6'd2,  lat: 4};
      vecs[3] = '{f: 5'd31, l: 5'd31, d: 32'h8000_0000, o: 6'd1,  lat: 1};

      #2;
      chk("rst_sel", 64'(sel), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_valid", 64'(result_valid), 64'd0);
      chk("rst_data", 64'(result_data), 64'd0);
      chk("rst_ones", 64'(result_ones), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Abort in IDLE blocks a simultaneous start.
      @(negedge clk);
      first_sel = 5'd3;
      last_sel  = 5'd9;
      start     = 1'b1;
      abort     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("idle_abort_busy", 64'(busy), 64'd0);
      chk("idle_abort_sel", 64'(sel), 64'd0);

      for (int i = 0; i < 3; i++) begin
         run_scan(vecs[i].f, vecs[i].l, vecs[i].d, vecs[i].o, vecs[i].lat);
         handshake();
      end

      // Single channel, then a long HOLD with start pulsed each cycle.
      run_scan(vecs[3].f, vecs[3].l, vecs[3].d, vecs[3].o, vecs[3].lat);
      vcnt = 0;
      for (int i = 0; i < 5; i++) begin
         start     = 1'b1;
         first_sel = 5'd0;
         last_sel  = 5'd31;
         @(negedge clk);
         if (result_valid === 1'b1 && busy === 1'b0 && sel === 5'd31 &&
             result_data === 32'h8000_0000 && result_ones === 6'd1) vcnt++;
      end
      start = 1'b0;
      chk("hold_stable_cycles", 64'(vcnt), 64'd5);
      handshake();
      @(negedge clk);
      chk("idle_after_hs", 64'(busy), 64'd0);

      // Abort mid-scan.
      @(negedge clk);
      first_sel = 5'd0;
      last_sel  = 5'd31;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_sel(5'd10, "abort_reach_sel");
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_valid", 64'(result_valid), 64'd0);
      chk("abort_data", 64'(result_data), 64'd0);
      chk("abort_ones", 64'(result_ones), 64'd0);
      chk("abort_sel_hold", 64'(sel), 64'd10);
      vcnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (result_valid !== 1'b0 || busy !== 1'b0) vcnt++;
      end
      chk("abort_stays_idle", 64'(vcnt), 64'd0);

      // Asynchronous reset mid-scan.
      @(negedge clk);
      first_sel = 5'd0;
      last_sel  = 5'd31;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_sel(5'd20, "reset_reach_sel");
      chk("pre_reset_data_nonzero", 64'(result_data != 32'd0), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_sel", 64'(sel), 64'd0);
      chk("async_rst_busy", 64'(busy), 64'd0);
      chk("async_rst_valid", 64'(result_valid), 64'd0);
      chk("async_rst_data", 64'(result_data), 64'd0);
      chk("async_rst_ones", 64'(result_ones), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_scan(5'd0, 5'd31, 32'hABCD_EF12, 6'd19, 32);
      handshake();

      chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequencer that sits directly upstream of the 32-to-1 mux tree.
- Drives the mux select, steps it across a programmed channel window, and samples the 1-bit mux output each cycle.
- Reassembles the sampled bits into a 32-bit result word with a ones count, returned over a valid/ready handshake.
- Used to scan and verify the mux datapath in-system; the mux itself stays purely combinational.

Parameters:
- SEL_W, 5, select width; channel count is 2**SEL_W (32).
- CNT_W, 6, ones-count width; equals SEL_W+1.

Ports:
- clk  input  1  rising-edge clock (single clock domain)
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a scan; accepted only in IDLE
- abort  input  1  synchronous scan cancel
- first_sel  input  SEL_W  first channel of window, sampled when start is accepted
- last_sel  input  SEL_W  last channel of window (inclusive), sampled when start is accepted
- mux_out  input  1  combinational output of the mux for the current sel
- sel  output  SEL_W  registered select driven to the mux
- busy  output  1  high in SCAN
- result_data  output  2**SEL_W  reassembled word; bit k = sample taken with sel==k; unscanned bits 0
- result_ones  output  CNT_W  number of 1 samples in the window
- result_valid  output  1  result available
- result_ready  input  1  consumer accepts the result

Behaviour:
- Reset (async, rst_n low) forces: state IDLE, sel=0, busy=0, result_valid=0, result_data=0, result_ones=0, latched window=0. Reset wins over every other event and can occur mid-scan.
- States:
  - IDLE: sel holds its last value. If start=1 and abort=0: latch first_sel/last_sel, set sel<=first_sel, clear result_data and result_ones, go to SCAN.
  - SCAN: busy=1. Every edge: result_data[sel]<=mux_out; result_ones+=mux_out. If sel==last: go to HOLD, result_valid<=1, sel unchanged. Otherwise sel<=sel+1, modulo 2**SEL_W (wrap 31->0).
  - HOLD: result_valid=1; result_data and result_ones are stable. If result_ready=1: result_valid<=0, go to IDLE.
- Sampling: mux_out is sampled on the same edge that advances sel. The mux is combinational, so the sample always matches the sel value driven during that cycle.
- Window length: n = ((last - first) mod 2**SEL_W) + 1.
  - first==last scans a single channel.
  - last<first wraps through 31->0.
  - A full scan is first=k, last=k-1 (mod 32).
- Latency: result_valid rises n edges after the edge that accepted start. The next start can be accepted on the edge after the handshake completes.
- start is ignored in SCAN and HOLD; it is not queued.
- abort:
  - In SCAN or HOLD: next edge goes to IDLE, result_valid=0, busy=0, result_data and result_ones cleared, sel holds.
  - In IDLE: no effect, and it blocks start that cycle.
- Simultaneous result_ready and abort in HOLD: abort wins and the result is discarded.
- result_ones cannot overflow: its maximum is 32 with CNT_W=6.

Decomposition:
- Shared package mux_scan_pkg holds:
  - SEL_W and N_CH constants.
  - scan_state_t enum {IDLE, SCAN, HOLD}.
  - A window-length function computing n from first/last.
- One natural sub-module: mux_scan_accum, the result register plus ones counter, with clear/enable/index inputs. The FSM and select counter stay in the top.
- The mux is instantiated only in the bench, not inside this block.

Test Plan:
- Bench mux model with inp=32'hABCD_EF12; first=0, last=31, pulse start -> sel steps 0..31, result_valid rises 32 edges after start, result_data=32'hABCD_EF12, result_ones=19.
- Same inp; first=4, last=7 -> result_data=32'h0000_0010, result_ones=1, valid after 4 edges, sel holds 7 in HOLD.
- Wrap window first=30, last=1 -> sel sequence 30,31,0,1; result_data=32'h8000_0002, result_ones=2, latency 4.
- first=last=31 -> result_data=32'h8000_0000, result_ones=1, latency 1. Then hold result_ready=0 for 5 cycles with start pulsed each cycle -> data stable, no restart; ready=1 -> IDLE next edge.
- Start full scan, assert abort at sel=10 -> IDLE next edge, busy=0, result_valid never rises, result_data=0.
- Start full scan, drop rst_n asynchronously at sel=20 (mid-cycle) -> all outputs reach reset values immediately, without waiting for a clock edge. Release rst_n, then start with first=0, last=31 -> completes normally with 32'hABCD_EF12.
